// File: rtl/dft_frame_sequencer.sv
// Frame controller for dft_accumulation: starts the accumulator, streams frame_len
// windowed samples, waits for the result and holds it until downstream takes it.
module dft_frame_sequencer #(
  parameter int IQ_WIDTH           = 16,
  parameter int SAMPLE_COUNT_WIDTH = 16,
  parameter int RESULT_TIMEOUT     = 1000
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic [SAMPLE_COUNT_WIDTH-1:0]       frame_len_i,
  input  logic                                s_valid_i,
  output logic                                s_ready_o,
  input  logic signed [IQ_WIDTH-1:0]          s_i_i,
  input  logic signed [IQ_WIDTH-1:0]          s_q_i,
  output logic [SAMPLE_COUNT_WIDTH-1:0]       win_addr_o,
  output logic                                osc_restart_o,
  output logic                                osc_step_o,
  output logic                                dft_start_o,
  output logic                                dft_sample_valid_o,
  output logic                                dft_last_sample_o,
  output logic signed [IQ_WIDTH-1:0]          dft_i_o,
  output logic signed [IQ_WIDTH-1:0]          dft_q_o,
  input  logic                                dft_valid_i,
  input  logic                                dft_busy_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [31:0]                         frame_cnt_o,
  output logic                                err_timeout_o
);

  localparam int SCW = SAMPLE_COUNT_WIDTH;
  localparam int TW  = $clog2(RESULT_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_RES, HOLD} state_t;

  state_t          state;
  logic [SCW-1:0]  idx;
  logic [SCW-1:0]  last_idx;
  logic [TW-1:0]   wait_cnt;
  logic            smp_vld;
  logic            launch;
  logic            accept;

  // Start/restart are decoded in the IDLE cycle so a frame can begin right
  // after the result handshake; reset masks them so nothing leaks out.
  assign launch        = (state == IDLE) && enable_i && !dft_busy_i && !rst_i;
  assign dft_start_o   = launch;
  assign osc_restart_o = launch;
  assign accept        = s_valid_i && s_ready_o;

  // The ROM registers the address on the accept edge, so its data lines up
  // with the registered sample one cycle later.
  assign win_addr_o         = idx;
  assign dft_sample_valid_o = smp_vld;
  assign osc_step_o         = smp_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      idx               <= '0;
      last_idx          <= '0;
      wait_cnt          <= '0;
      smp_vld           <= 1'b0;
      dft_last_sample_o <= 1'b0;
      dft_i_o           <= '0;
      dft_q_o           <= '0;
      s_ready_o         <= 1'b0;
      res_valid_o       <= 1'b0;
      frame_cnt_o       <= '0;
      err_timeout_o     <= 1'b0;
    end else begin
      smp_vld           <= 1'b0;
      dft_last_sample_o <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            last_idx <= (frame_len_i == '0) ? '0 : frame_len_i - SCW'(1);
            idx      <= '0;
            state    <= START;
          end
        end
        START: begin
          s_ready_o <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            dft_i_o           <= s_i_i;
            dft_q_o           <= s_q_i;
            smp_vld           <= 1'b1;
            dft_last_sample_o <= (idx == last_idx);
            if (idx == last_idx) begin
              s_ready_o <= 1'b0;
              wait_cnt  <= '0;
              state     <= WAIT_RES;
            end else begin
              idx <= idx + SCW'(1);
            end
          end
        end
        WAIT_RES: begin
          if (dft_valid_i) begin
            frame_cnt_o <= frame_cnt_o + 32'd1;
            res_valid_o <= 1'b1;
            state       <= HOLD;
          end else if (wait_cnt == TW'(RESULT_TIMEOUT - 1)) begin
            err_timeout_o <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        HOLD: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Scoreboard bench for dft_frame_sequencer: drivers push expected samples, a
// negedge monitor pops them whenever the DUT presents dft_sample_valid_o.
module tb_dft_frame_sequencer;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                enable_i = 1'b0;
  logic [15:0]         frame_len_i = '0;
  logic                s_valid_i = 1'b0;
  logic                s_ready_o;
  logic signed [15:0]  s_i_i = '0;
  logic signed [15:0]  s_q_i = '0;
  logic [15:0]         win_addr_o;
  logic                osc_restart_o, osc_step_o, dft_start_o;
  logic                dft_sample_valid_o, dft_last_sample_o;
  logic signed [15:0]  dft_i_o, dft_q_o;
  logic                dft_valid_i = 1'b0;
  logic                dft_busy_i = 1'b0;
  logic                res_valid_o;
  logic                res_ready_i = 1'b1;
  logic [31:0]         frame_cnt_o;
  logic                err_timeout_o;

  dft_frame_sequencer #(.IQ_WIDTH(16), .SAMPLE_COUNT_WIDTH(16), .RESULT_TIMEOUT(1000)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .frame_len_i(frame_len_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_i_i(s_i_i), .s_q_i(s_q_i),
    .win_addr_o(win_addr_o), .osc_restart_o(osc_restart_o), .osc_step_o(osc_step_o),
    .dft_start_o(dft_start_o), .dft_sample_valid_o(dft_sample_valid_o),
    .dft_last_sample_o(dft_last_sample_o), .dft_i_o(dft_i_o), .dft_q_o(dft_q_o),
    .dft_valid_i(dft_valid_i), .dft_busy_i(dft_busy_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .frame_cnt_o(frame_cnt_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [15:0]        addr;
    logic               last;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   cyc = 0, step_cnt = 0, start_cnt = 0, exp_frames = 0;
  bit   dft_auto = 1'b1;
  logic [15:0] rom_q = '0;

  always @(posedge clk) cyc <= cyc + 1;
  // Window ROM model: 1-cycle read latency, content addr*3+7.
  always @(posedge clk) rom_q <= 16'(win_addr_o * 3 + 7);

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_i) begin
      if (dft_start_o) start_cnt++;
      if (osc_step_o) step_cnt++;
      if (dft_start_o || osc_restart_o) chk("restart_vs_start", osc_restart_o, dft_start_o);
      if (osc_step_o || dft_sample_valid_o) chk("step_vs_valid", osc_step_o, dft_sample_valid_o);
      if (dft_sample_valid_o) begin
        if (sbq.size() == 0) bad("unexpected_sample");
        else begin
          mon_e = sbq.pop_front();
          chk("sample_i", dft_i_o, mon_e.i);
          chk("sample_q", dft_q_o, mon_e.q);
          chk("window_rom", rom_q, 16'(mon_e.addr * 3 + 7));
          chk("last_flag", dft_last_sample_o, mon_e.last);
        end
      end else if (dft_last_sample_o) bad("last_without_valid");
    end
  end

  // Accumulator model: valid 3 cycles after the last sample.
  initial forever begin
    @(negedge clk);
    if (dft_auto && !rst_i && dft_sample_valid_o && dft_last_sample_o) begin
      repeat (3) @(negedge clk);
      dft_valid_i = 1'b1;
      @(negedge clk);
      dft_valid_i = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic stream(input int len, input bit bubble, input int max_acc, output int last_cyc);
    int n = 0;
    int k = 0;
    exp_t x;
    last_cyc = 0;
    while (n < max_acc && k < 400) begin
      @(negedge clk);
      s_valid_i = !(bubble && k[0]);
      s_i_i = 16'(100 + k * 7);
      s_q_i = 16'(-3 * k - 1);
      if (s_valid_i && s_ready_o) begin
        x.i = s_i_i; x.q = s_q_i; x.addr = 16'(n); x.last = (n == len - 1);
        sbq.push_back(x);
        last_cyc = cyc;
        n++;
      end
      k++;
    end
    if (n < max_acc) bad("stream_timeout");
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic wait_start();
    bit ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (dft_start_o) begin ok = 1'b1; break; end
    end
    if (!ok) bad("start_timeout");
  endtask

  task automatic wait_res();
    bit ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (res_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) bad("res_valid_timeout");
  endtask

  task automatic run_frame(input int len, input bit bubble);
    int eff = (len == 0) ? 1 : len;
    int s0, st0, lc;
    frame_len_i = 16'(len);
    res_ready_i = 1'b1;
    st0 = start_cnt;
    @(posedge clk); #1;
    dft_busy_i = 1'b0;
    enable_i = 1'b1;
    wait_start();
    @(negedge clk);
    enable_i = 1'b0;
    frame_len_i = 16'(len + 3);
    s0 = step_cnt;
    stream(eff, bubble, eff, lc);
    wait_res();
    exp_frames++;
    chk("frame_cnt", frame_cnt_o, exp_frames);
    chk("steps_per_frame", step_cnt - s0, eff);
    chk("starts_per_frame", start_cnt - st0, 1);
    @(negedge clk);
    chk("res_valid_after_hs", res_valid_o, 0);
  endtask

  initial begin
    int lc, hv, e_cyc;
    // Reset state, with enable high to show the start pulse is masked
    enable_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_dft_start", dft_start_o, 0);
    chk("rst_sample_valid", dft_sample_valid_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    chk("rst_err", err_timeout_o, 0);
    chk("rst_win_addr", win_addr_o, 0);
    enable_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);

    // Single frame of 8, then bubbles with 16
    run_frame(8, 1'b0);
    run_frame(16, 1'b1);

    // Back-to-back with a slow consumer
    frame_len_i = 16'd4;
    res_ready_i = 1'b0;
    @(posedge clk); #1;
    enable_i = 1'b1;
    stream(4, 1'b0, 4, lc);
    wait_res();
    hv = 0;
    for (int c = 1; c <= 6; c++) begin
      if (res_valid_o) hv++;
      chk("b2b_s_ready_low", s_ready_o, 0);
      if (c == 6) res_ready_i = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    chk("b2b_res_valid_cycles", hv, 6);
    chk("b2b_second_start", dft_start_o, 1);
    chk("b2b_res_valid_dropped", res_valid_o, 0);
    @(negedge clk);
    enable_i = 1'b0;
    stream(4, 1'b0, 4, lc);
    wait_res();
    exp_frames += 2;
    chk("b2b_frame_cnt", frame_cnt_o, exp_frames);
    @(negedge clk);

    // Busy accumulator blocks the start; then lengths 0 and 1
    dft_busy_i = 1'b1;
    frame_len_i = '0;
    @(posedge clk); #1;
    enable_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_start_when_busy", dft_start_o, 0);
    end
    run_frame(0, 1'b0);
    run_frame(1, 1'b0);

    // Result timeout
    dft_auto = 1'b0;
    frame_len_i = 16'd2;
    @(posedge clk); #1;
    enable_i = 1'b1;
    wait_start();
    @(negedge clk);
    enable_i = 1'b0;
    stream(2, 1'b0, 2, lc);
    e_cyc = lc + 1;
    for (int t = 0; t < 1200; t++) begin
      if (cyc >= e_cyc + 999) break;
      @(negedge clk);
    end
    chk("timeout_not_early", err_timeout_o, 0);
    @(negedge clk);
    chk("timeout_err_set", err_timeout_o, 1);
    chk("timeout_idle_ready", s_ready_o, 0);
    chk("timeout_no_result", res_valid_o, 0);
    chk("timeout_frame_cnt", frame_cnt_o, exp_frames);
    @(negedge clk);
    chk("timeout_sticky", err_timeout_o, 1);
    chk("timeout_no_restart", dft_start_o, 0);
    dft_auto = 1'b1;

    // Reset mid-stream at sample 3 of 8, enable held high
    frame_len_i = 16'd8;
    @(posedge clk); #1;
    enable_i = 1'b1;
    stream(8, 1'b0, 3, lc);
    #2;
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready_o, 0);
    chk("mid_rst_sample_valid", dft_sample_valid_o, 0);
    chk("mid_rst_step", osc_step_o, 0);
    chk("mid_rst_start", dft_start_o, 0);
    chk("mid_rst_win_addr", win_addr_o, 0);
    chk("mid_rst_frame_cnt", frame_cnt_o, 0);
    chk("mid_rst_err", err_timeout_o, 0);
    chk("mid_rst_sb_empty", sbq.size(), 0);
    exp_frames = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_i = 1'b0;
    wait_start();
    @(negedge clk);
    enable_i = 1'b0;
    stream(8, 1'b0, 8, lc);
    wait_res();
    exp_frames++;
    chk("post_rst_frame_cnt", frame_cnt_o, exp_frames);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dft_frame_sequencer.md
# dft_frame_sequencer

Frame-level controller for `dft_accumulation`. It accepts an I/Q sample stream and a frame-length configuration, and pulses `start` to the accumulator. It then forwards exactly `frame_len` samples with window-ROM addressing and oscillator stepping, flags the last sample, and waits for the accumulator's `valid`. Finally it holds a result handshake towards the downstream magnitude/peak stage. It sits between the ADC capture FIFO and `dft_accumulation`, and owns the window ROM address and the oscillator-bank restart/step controls.

## Interface
- `IQ_WIDTH`, 16, I/Q sample width.
- `SAMPLE_COUNT_WIDTH`, 16, width of frame length and sample index.
- `RESULT_TIMEOUT`, 1000, maximum cycles in WAIT_RES before an error is raised.

- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `enable_i` in 1: level; when 1, frames run back-to-back.
- `frame_len_i` in SAMPLE_COUNT_WIDTH: samples per frame, latched at frame start; 0 is treated as 1.
- `s_valid_i` in 1 / `s_ready_o` out 1: input stream handshake.
- `s_i_i`, `s_q_i` in IQ_WIDTH signed: input sample.
- `win_addr_o` out SAMPLE_COUNT_WIDTH: window ROM address; the ROM has 1-cycle read latency and its output feeds the DFT directly.
- `osc_restart_o` out 1: one-cycle pulse that resets oscillator phase to bin start.
- `osc_step_o` out 1: advances the oscillators one sample.
- `dft_start_o`, `dft_sample_valid_o`, `dft_last_sample_o` out 1: DFT control outputs.
- `dft_i_o`, `dft_q_o` out IQ_WIDTH signed: registered sample to the DFT.
- `dft_valid_i`, `dft_busy_i` in 1: DFT status inputs.
- `res_valid_o` out 1 / `res_ready_i` in 1: result handshake; the DFT A outputs are stable while `res_valid_o` is 1.
- `frame_cnt_o` out 32: completed frames, wraps modulo 2^32.
- `err_timeout_o` out 1: sticky; cleared only by reset.

## Operation
FSM with states IDLE, START, STREAM, WAIT_RES, HOLD.
- **IDLE**
  - If `enable_i`=1: latch `frame_len`, clear the index, drive `dft_start_o`=1 and `osc_restart_o`=1 for this one cycle, then go to START.
- **START**
  - One cycle; lets the DFT clear its accumulators.
  - Go to STREAM.
- **STREAM**
  - `s_ready_o`=1.
  - An accepted beat (`s_valid_i` and `s_ready_o`):
    - sets `win_addr_o` = index in the same cycle;
    - registers I/Q;
    - increments the index.
  - One cycle after acceptance:
    - `dft_sample_valid_o`=1 with the registered I/Q, aligned with the ROM output;
    - `osc_step_o`=1, pulsing in the same cycle as the sample it is used with;
    - `dft_last_sample_o`=1 iff that beat had index `frame_len`−1.
  - Input bubbles (`s_valid_i`=0) produce no `dft_sample_valid_o` or `osc_step_o`; the index holds.
  - On acceptance of index `frame_len`−1: `s_ready_o` drops the next cycle, then go to WAIT_RES.
- **WAIT_RES**
  - `s_ready_o`=0; count cycles.
  - On `dft_valid_i`=1: go to HOLD and increment `frame_cnt_o`.
  - On count = `RESULT_TIMEOUT`: set `err_timeout_o`, go to IDLE.
- **HOLD**
  - `res_valid_o`=1, held until `res_ready_i`=1.
  - On handshake: go to IDLE.
  - If `enable_i` is still 1, IDLE starts the next frame the following cycle.
- **`enable_i` falling mid-frame:** the current frame completes; no new frame starts.
- **`frame_len_i` changing mid-frame:** ignored until the next IDLE→START.
- **`dft_busy_i`=1 while in IDLE:** start is not issued; wait.
- **`dft_valid_i` outside WAIT_RES:** ignored.

## Timing
- **Reset values:**
  - all outputs 0, `s_ready_o`=0, counters 0;
  - state IDLE;
  - `err_timeout_o` 0.
- **Reset mid-operation:** immediate return to IDLE with all pulses low; no partial result is flagged.
- **Latency, accepted beat to `dft_sample_valid_o`:** 1 cycle.
- **Latency, last accept to WAIT_RES entry:** 1 cycle.
- **Minimum frame cycles:** 2 + `frame_len` + 1 + DFT latency + 1 + handshake.
- **Pulse widths:** `dft_start_o` and `osc_restart_o` are exactly 1 cycle.
- **Step count:** `osc_step_o` pulses exactly `frame_len` times per frame.
- **Index counter:**
  - never exceeds `frame_len`−1;
  - at `frame_len` = 2^SAMPLE_COUNT_WIDTH−1, wraps are illegal;
  - `frame_len` = 0 behaves as 1.
- **`frame_cnt_o`:** updates in the cycle after `dft_valid_i` is seen.

## Test plan
- **Single frame:** `frame_len`=8, continuous valid.
  - One `dft_start_o` pulse.
  - 8 `dft_sample_valid_o` with `win_addr_o` 0..7.
  - `dft_last_sample_o` on the 8th only.
  - `res_valid_o` after `dft_valid_i`; `frame_cnt_o`=1.
- **Bubbles:** `frame_len`=16, `s_valid_i` toggled every other cycle.
  - Exactly 16 steps/samples, order preserved.
  - No step pulses during gaps.
- **Back-to-back frames:** `enable_i` held high, `frame_len`=4, `res_ready_i` held low 5 cycles then high.
  - `res_valid_o` stays high 6 cycles.
  - `s_ready_o` stays 0 throughout.
  - Second `dft_start_o` appears 1 cycle after the handshake.
- **Timeout:** DFT model never asserts valid, `RESULT_TIMEOUT`=1000.
  - `err_timeout_o`=1 exactly 1000 cycles after WAIT_RES entry; FSM in IDLE.
- **Reset mid-stream:** `rst_i` asserted at sample 3 of 8.
  - All outputs 0 immediately.
  - After release with `enable_i`=1, a fresh `dft_start_o` and `win_addr_o` restarts at 0.
- **Edge length:** `frame_len`=0 and `frame_len`=1.
  - Each produces one sample with `dft_last_sample_o`=1 on that sample.
